// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: CSR write port and pipeline redirect strobe driven by trap_ctrl
interface trap_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] data_o;
  logic [AW-1:0] int_addr_o;
  logic          int_assert_o;
  modport master (output we_o, waddr_o, data_o, int_addr_o, int_assert_o);
  modport slave (input we_o, waddr_o, data_o, int_addr_o, int_assert_o);
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: sync trap / MRET / external-software-timer interrupt sequencer writing mepc, mstatus, mcause.
// Define TRAP_VECTORED_EN to enable vectored handler addressing (mtvec[1:0]=01, async traps only).
module trap_ctrl #(
  parameter int NUM_EXT_IRQ = 4,
  parameter int EXT_ID_W = (NUM_EXT_IRQ > 1) ? $clog2(NUM_EXT_IRQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst_i,
  input  logic [31:0]            inst_addr_i,
  input  logic                   jump_flag_i,
  input  logic [31:0]            jump_addr_i,
  input  logic                   div_started_i,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq_en_i,
  input  logic                   timer_irq_i,
  input  logic                   sw_irq_i,
  input  logic [31:0]            csr_mtvec,
  input  logic [31:0]            csr_mepc,
  input  logic [31:0]            csr_mstatus,
  input  logic [31:0]            csr_mie,
  output logic                   hold_flag_o,
  trap_ctrl_if.master            bus,
  output logic [NUM_EXT_IRQ-1:0] ext_ack_o,
  output logic [EXT_ID_W-1:0]    ext_irq_id_o
);
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET = 32'h3020_0073;
  typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET} state_t;
  state_t r_state, w_next;
  logic [NUM_EXT_IRQ-1:0] w_ext;
  logic w_ext_any, w_sw, w_tmr, w_sync, w_mret, w_async, w_trap;
  logic [EXT_ID_W-1:0] w_id, r_id;
  logic [31:0] w_cause, w_handler, r_cause, r_mepc;
  logic r_ext;
  assign w_ext = ext_irq_i & ext_irq_en_i;
  assign w_ext_any = csr_mie[11] & (|w_ext);
  assign w_sw = csr_mie[3] & sw_irq_i;
  assign w_tmr = csr_mie[7] & timer_irq_i;
  assign w_sync = (inst_i == ECALL || inst_i == EBREAK) && !div_started_i;
  assign w_mret = inst_i == MRET;
  assign w_async = csr_mstatus[3] & (w_ext_any | w_sw | w_tmr) & ~div_started_i;
  assign w_trap = w_sync | (~w_mret & w_async);
  assign hold_flag_o = (r_state != S_IDLE) || w_sync || w_mret || w_async;
  assign w_cause = w_sync ? ((inst_i == ECALL) ? 32'd11 : 32'd3) :
                   w_ext_any ? 32'h8000_000B : w_sw ? 32'h8000_0003 : 32'h8000_0007;
`ifdef TRAP_VECTORED_EN
  assign w_handler = {csr_mtvec[31:2], 2'b00} +
                     ((csr_mtvec[1:0] == 2'b01 && r_cause[31]) ? {r_cause[29:0], 2'b00} : 32'd0);
`else
  assign w_handler = {csr_mtvec[31:2], 2'b00};
`endif
  // lowest-index enabled external channel wins
  always_comb begin
    w_id = '0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) w_id = w_ext[i] ? EXT_ID_W'(i) : w_id;
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = w_trap ? S_MEPC : w_mret ? S_MRET : S_IDLE;
      S_MEPC: w_next = S_MSTATUS;
      S_MSTATUS: w_next = S_MCAUSE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we_o <= 1'b0;
      bus.waddr_o <= '0;
      bus.data_o <= '0;
      bus.int_addr_o <= '0;
      bus.int_assert_o <= 1'b0;
      ext_ack_o <= '0;
      ext_irq_id_o <= '0;
      r_cause <= '0;
      r_mepc <= '0;
      r_id <= '0;
      r_ext <= 1'b0;
    end else begin
      bus.we_o <= 1'b0;
      bus.waddr_o <= '0;
      bus.data_o <= '0;
      bus.int_addr_o <= '0;
      bus.int_assert_o <= 1'b0;
      ext_ack_o <= '0;
      case (r_state)
        S_IDLE: if (w_trap) begin
          r_cause <= w_cause;
          r_mepc <= (!w_sync && jump_flag_i) ? jump_addr_i : inst_addr_i;
          r_id <= w_id;
          r_ext <= ~w_sync & w_ext_any;
        end
        S_MEPC: begin
          bus.we_o <= 1'b1;
          bus.waddr_o <= 32'h341;
          bus.data_o <= r_mepc;
        end
        S_MSTATUS: begin
          bus.we_o <= 1'b1;
          bus.waddr_o <= 32'h300;
          bus.data_o <= {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
        end
        S_MCAUSE: begin
          bus.we_o <= 1'b1;
          bus.waddr_o <= 32'h342;
          bus.data_o <= r_cause;
          bus.int_assert_o <= 1'b1;
          bus.int_addr_o <= w_handler;
          if (r_ext) begin
            ext_ack_o <= NUM_EXT_IRQ'(1) << r_id;
            ext_irq_id_o <= r_id;
          end
        end
        default: begin
          bus.we_o <= 1'b1;
          bus.waddr_o <= 32'h300;
          bus.data_o <= {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};
          bus.int_assert_o <= 1'b1;
          bus.int_addr_o <= csr_mepc;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a spec-level reference model
module tb_trap_ctrl;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] inst, iaddr, jaddr, mtvec, mepc_c, mstatus, mie;
  logic jflag, div, tmr, sw;
  logic [3:0] eirq, een, ack;
  logic [1:0] id;
  logic hold;
  logic [1:0] exp_id;
  int checks = 0, errors = 0;
  trap_ctrl_if bus ();
  trap_ctrl #(.NUM_EXT_IRQ(4)) dut (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(iaddr), .jump_flag_i(jflag),
    .jump_addr_i(jaddr), .div_started_i(div), .ext_irq_i(eirq), .ext_irq_en_i(een),
    .timer_irq_i(tmr), .sw_irq_i(sw), .csr_mtvec(mtvec), .csr_mepc(mepc_c),
    .csr_mstatus(mstatus), .csr_mie(mie), .hold_flag_o(hold), .bus(bus.master),
    .ext_ack_o(ack), .ext_irq_id_o(id)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    inst = NOP; eirq = '0; een = '0; tmr = 0; sw = 0; div = 0; jflag = 0;
  endtask
  task automatic idle_quiet(input string tag);
    chk({tag, "_we"}, {31'd0, bus.we_o}, 32'd0);
    chk({tag, "_assert"}, {31'd0, bus.int_assert_o}, 32'd0);
    chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
  endtask
  // Reference: decide the outcome from the priority rules, then walk the expected CSR sequence.
  task automatic run(input string tag);
    int kind, eid;
    logic [31:0] cause, epc, hnd, ms_trap, ms_ret;
    kind = 0; cause = 0; epc = 0; eid = -1;
    if ((inst == ECALL || inst == EBREAK) && !div) begin
      kind = 1; cause = (inst == ECALL) ? 11 : 3; epc = iaddr;
    end else if (inst == MRET) kind = 2;
    else if (mstatus[3] && !div) begin
      for (int i = 3; i >= 0; i--) if (mie[11] && eirq[i] && een[i]) eid = i;
      if (eid >= 0) cause = 32'h8000_000B;
      else if (mie[3] && sw) cause = 32'h8000_0003;
      else if (mie[7] && tmr) cause = 32'h8000_0007;
      if (cause != 0) begin kind = 1; epc = jflag ? jaddr : iaddr; end
    end
    hnd = (mtvec & ~32'd3) + ((VEC && mtvec[1:0] == 2'b01 && cause[31]) ? (cause & 32'h7FFF_FFFF) * 4 : 0);
    ms_trap = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
    ms_ret = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
    #1 chk({tag, "_hold"}, {31'd0, hold}, {31'd0, kind != 0});
    step();
    inst = NOP;
    idle_quiet({tag, "_c0"});
    if (kind == 0) begin
      step();
      idle_quiet({tag, "_none"});
    end else if (kind == 1) begin
      step();
      chk({tag, "_mepc_we"}, {31'd0, bus.we_o}, 32'd1);
      chk({tag, "_mepc_addr"}, bus.waddr_o, 32'h341);
      chk({tag, "_mepc_data"}, bus.data_o, epc);
      chk({tag, "_mepc_assert"}, {31'd0, bus.int_assert_o}, 32'd0);
      step();
      chk({tag, "_ms_we"}, {31'd0, bus.we_o}, 32'd1);
      chk({tag, "_ms_addr"}, bus.waddr_o, 32'h300);
      chk({tag, "_ms_data"}, bus.data_o, ms_trap);
      step();
      if (eid >= 0) exp_id = eid[1:0];
      chk({tag, "_mc_we"}, {31'd0, bus.we_o}, 32'd1);
      chk({tag, "_mc_addr"}, bus.waddr_o, 32'h342);
      chk({tag, "_mc_data"}, bus.data_o, cause);
      chk({tag, "_assert"}, {31'd0, bus.int_assert_o}, 32'd1);
      chk({tag, "_int_addr"}, bus.int_addr_o, hnd);
      chk({tag, "_ack"}, {28'd0, ack}, (eid >= 0) ? (32'd1 << eid) : 32'd0);
      chk({tag, "_id"}, {30'd0, id}, {30'd0, exp_id});
    end else begin
      step();
      chk({tag, "_ret_we"}, {31'd0, bus.we_o}, 32'd1);
      chk({tag, "_ret_addr"}, bus.waddr_o, 32'h300);
      chk({tag, "_ret_data"}, bus.data_o, ms_ret);
      chk({tag, "_ret_assert"}, {31'd0, bus.int_assert_o}, 32'd1);
      chk({tag, "_ret_int_addr"}, bus.int_addr_o, mepc_c);
      chk({tag, "_ret_ack"}, {28'd0, ack}, 32'd0);
    end
  endtask
  initial begin
    clr();
    iaddr = 0; jaddr = 0; mtvec = 0; mepc_c = 0; mstatus = 0; mie = 0; exp_id = 0;
    step();
    step();
    idle_quiet("reset");
    chk("reset_waddr", bus.waddr_o, 32'd0);
    chk("reset_data", bus.data_o, 32'd0);
    chk("reset_id", {30'd0, id}, 32'd0);
    rst = 0;
    #1 chk("reset_hold", {31'd0, hold}, 32'd0);
    step();
    inst = ECALL; iaddr = 32'h100; mtvec = 32'h200; mstatus = 32'h8;
    run("ecall");
    clr();
    step();
    idle_quiet("ecall_after");
    eirq = 4'b0110; een = 4'hF; mie = 32'h888; mstatus = 32'h8; mtvec = 32'h201; iaddr = 32'h400;
    run("ext");
    clr();
    tmr = 1; sw = 1; mtvec = 32'h300;
    run("sw_over_tmr");
    clr();
    tmr = 1; sw = 1; mstatus = 32'h0;
    run("mie_off");
    clr();
    mstatus = 32'h8; inst = ECALL; div = 1; eirq = 4'hF; een = 4'hF;
    run("div_busy");
    clr();
    mstatus = 32'h8; eirq = 4'b1000; een = 4'hF; inst = ECALL; iaddr = 32'h500;
    run("sync_first");
    inst = MRET; mepc_c = 32'h504;
    run("mret_between");
    iaddr = 32'h504; jflag = 1; jaddr = 32'h600;
    run("ext_after_mret");
    clr();
    inst = MRET; mstatus = 32'h80; mepc_c = 32'h340;
    run("mret");
    clr();
    inst = EBREAK; mstatus = 32'h8; iaddr = 32'h700;
    #1 chk("rst_hold", {31'd0, hold}, 32'd1);
    step();
    inst = NOP;
    step();
    chk("rst_pre_we", {31'd0, bus.we_o}, 32'd1);
    rst = 1;
    step();
    exp_id = 0;
    idle_quiet("rst_mid");
    chk("rst_mid_hold", {31'd0, hold}, 32'd0);
    chk("rst_mid_id", {30'd0, id}, 32'd0);
    rst = 0;
    step();
    idle_quiet("rst_after1");
    step();
    idle_quiet("rst_after2");
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      inst = (sel == 0) ? ECALL : (sel == 1) ? EBREAK : (sel == 2) ? MRET : NOP;
      iaddr = $urandom & ~32'd3; jaddr = $urandom & ~32'd3; jflag = $urandom_range(0, 1) == 1;
      div = $urandom_range(0, 3) == 0;
      eirq = 4'($urandom); een = 4'($urandom); tmr = $urandom_range(0, 1) == 1; sw = $urandom_range(0, 1) == 1;
      mie = $urandom; mstatus = $urandom; mtvec = $urandom; mepc_c = $urandom;
      run("rand");
      clr();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
